vga_board_renderer: RTL and testbench
=====================================

// Module: vga_board_renderer
// PURPOSE
// - Pixel-generation stage placed directly after the VGA sync controller. It consumes the
//   controller's hCounter/vCounter/vidOn/hSync/vSync and drives RGB for the DAC.
// - Draws a ROWS x COLS game board held in an internal cell register file, plus a cursor
//   outline. The file is writable from game logic.
// - Two-stage registered pipeline. The syncs are delayed to stay aligned with the RGB outputs.
// PARAMETERS
// - GRID_X0      160  left pixel of board (hCounter units)
// - GRID_Y0       80  top pixel of board (vCounter units)
// - CELL_LOG2      6  log2 cell size in pixels (64 px cells)
// - COLS           3  board columns (1..8)
// - ROWS           3  board rows (1..8)
// - BLINK_FRAMES  30  frames per cursor blink half-period (CURSOR_BLINK_EN only)
// PORTS
// - clock      in   1   pixel clock (same divided clock as the sync controller)
// - reset      in   1   asynchronous, active-high
// - h_count    in  10   hCounter from sync controller
// - v_count    in  10   vCounter from sync controller
// - vid_on     in   1   active-video flag from sync controller
// - hsync_in   in   1   hSync from sync controller (active low)
// - vsync_in   in   1   vSync from sync controller (active low)
// - wr_en      in   1   cell write strobe
// - wr_col     in   3   cell column to write
// - wr_row     in   3   cell row to write
// - wr_data    in   2   cell value: 0 empty, 1 player A, 2 player B, 3 win mark
// - cur_col    in   3   cursor column
// - cur_row    in   3   cursor row
// - hsync_out  out  1   hsync_in delayed 2 clocks
// - vsync_out  out  1   vsync_in delayed 2 clocks
// - red        out  8   pixel red
// - green      out  8   pixel green
// - blue       out  8   pixel blue
// BEHAVIOUR
// - Reset (async): all cells = 0; red/green/blue = 0; hsync_out = vsync_out = 1; pipeline
//   regs cleared (vid_on pipe = 0); blink phase = 1; frame counter = 0.
// - Stage 1: dx = h_count - GRID_X0, dy = v_count - GRID_Y0 (11-bit signed).
//   - in_grid = dx,dy >= 0 and dx < COLS<<CELL_LOG2 and dy < ROWS<<CELL_LOG2.
//   - col = dx>>CELL_LOG2, row = dy>>CELL_LOG2.
//   - edge = low CELL_LOG2 bits of dx or dy equal to 0 or all-ones.
//   - Register col, row, edge, in_grid, vid_on, hsync_in, vsync_in.
// - Stage 2: read cell[row][col] and register RGB with this priority:
//   - vid_on=0 -> 000000
//   - !in_grid -> 000000
//   - edge && cursor cell && cursor visible -> FFFF00
//   - edge -> FFFFFF
//   - otherwise cell colour: 0 -> 202020, 1 -> FF0000, 2 -> 0000FF, 3 -> 00FF00
// - Latency: input pixel at clock edge N appears on red/green/blue/sync outputs after edge N+2.
// - Writes: on clock edge with wr_en=1, cell[wr_row][wr_col] <= wr_data.
//   - wr_col >= COLS or wr_row >= ROWS: write ignored, no other cell altered.
//   - Write and stage-2 read of the same cell in one cycle: read returns the old value.
//     The new value is used from the next clock.
// - Cursor with cur_col/cur_row out of range: no cursor drawn.
// - Reset asserted mid-frame: outputs go to reset values immediately. Rendering resumes
//   2 clocks after release, following the input counters; no resync is needed.
// CONFIGURATION
// - CURSOR_BLINK_EN defined:
//   - Frame end = h_count==799 && v_count==524.
//   - A frame counter counts frame ends 0..BLINK_FRAMES-1. At BLINK_FRAMES-1 it wraps to 0
//     and the blink phase toggles.
//   - Cursor is visible only while phase=1.
// - CURSOR_BLINK_EN undefined: no frame counter or phase logic; cursor is always visible.
// TESTING
// - Reset, then h=0,v=0,vid_on=1 -> RGB 000000, hsync_out=1, vsync_out=1.
// - Write cell(1,1)=1, then h=GRID_X0+96, v=GRID_Y0+96 -> FF0000 exactly 2 clocks later.
// - h=GRID_X0+64 (cell edge), v=GRID_Y0+10, cursor (0,2) -> FFFFFF.
//   - Same pixel with cursor (1,0) -> FFFF00.
// - wr_en with wr_col=3 (COLS=3) -> all 9 cells unchanged on readback scan.
//   - Same-cycle write/read of one cell -> old colour, then new colour next pixel.
// - hsync_in pulse at h=655..750 -> hsync_out low for the 96 clocks starting 2 clocks later.
//   - vid_on=0 inside grid -> 000000.
// - CURSOR_BLINK_EN, BLINK_FRAMES=2 -> cursor edge is FFFF00 in frames 0-1, FFFFFF in
//   frames 2-3, FFFF00 in frame 4.

Source files
------------

// File: rtl/vga_board_renderer.sv
// Board renderer: draws a ROWS x COLS cell board with a cursor outline from the VGA sync counters.
// Latency: 2 clocks from h_count/v_count/syncs to red/green/blue/hsync_out/vsync_out.
// No backpressure: free-running pixel pipeline. Optional cursor blink via `CURSOR_BLINK_EN.
module vga_board_renderer #(
  parameter int GRID_X0   = 160,
  parameter int GRID_Y0   = 80,
  parameter int CELL_LOG2 = 6,
  parameter int COLS      = 3,
  parameter int ROWS      = 3
`ifdef CURSOR_BLINK_EN
  , parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       vid_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_data,
  input  logic [2:0] cur_col,
  input  logic [2:0] cur_row,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam int GRID_W = COLS << CELL_LOG2;
  localparam int GRID_H = ROWS << CELL_LOG2;

  // ---------------- stage 1: position decode ----------------
  logic signed [10:0] dx, dy;
  logic [2:0] col_d, row_d, col_q, row_q;
  logic       in_grid_d, edge_d;
  logic       in_grid_q, edge_q, vid_q, hs1_q, vs1_q;

  assign dx = $signed({1'b0, h_count}) - 11'(GRID_X0);
  assign dy = $signed({1'b0, v_count}) - 11'(GRID_Y0);

  assign in_grid_d = !dx[10] && !dy[10] && (dx < 11'(GRID_W)) && (dy < 11'(GRID_H));
  assign col_d     = dx[CELL_LOG2+2:CELL_LOG2];
  assign row_d     = dy[CELL_LOG2+2:CELL_LOG2];
  // A pixel on the first or last line/column of a cell is part of the cell outline.
  assign edge_d    = (dx[CELL_LOG2-1:0] == '0) || (dx[CELL_LOG2-1:0] == '1) ||
                     (dy[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '1);

  // Stage-1 pipeline register; syncs idle high through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      in_grid_q <= 1'b0;
      edge_q    <= 1'b0;
      vid_q     <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      in_grid_q <= in_grid_d;
      edge_q    <= edge_d;
      vid_q     <= vid_on;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
    end
  end

  // ---------------- cell register file ----------------
  logic [1:0] cell_q [ROWS][COLS];

  // Game-logic writes; out-of-range coordinates match no cell and are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cell_q[r][c] <= 2'd0;
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (wr_row == 3'(r) && wr_col == 3'(c))
            cell_q[r][c] <= wr_data;
    end
  end

  // Stage-2 read of the cell under the pixel; sees the pre-write value on a same-cycle write.
  logic [1:0] cell_rd;
  always_comb begin
    cell_rd = 2'd0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_q == 3'(r) && col_q == 3'(c))
          cell_rd = cell_q[r][c];
  end

  // ---------------- cursor blink ----------------
  logic cursor_vis;
`ifdef CURSOR_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_d, frame_q;
  logic          phase_d, phase_q;
  logic          frame_end;

  assign frame_end = (h_count == 10'd799) && (v_count == 10'd524);

  // Count frame ends; toggle the blink phase every BLINK_FRAMES frames.
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = !phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Blink state register; starts in the visible phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      phase_q <= 1'b1;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign cursor_vis = phase_q;
`else
  assign cursor_vis = 1'b1;
`endif

  // ---------------- stage 2: colour select ----------------
  logic        cursor_hit;
  logic [23:0] rgb_d, rgb_q;
  logic        hs2_q, vs2_q;

  // col_q/row_q are always in range inside the grid, so an out-of-range cursor never matches.
  assign cursor_hit = (col_q == cur_col) && (row_q == cur_row);

  // Colour priority: blanking, off-board, cursor outline, cell outline, cell fill.
  always_comb begin
    rgb_d = 24'h000000;
    if (vid_q && in_grid_q) begin
      if (edge_q && cursor_hit && cursor_vis) begin
        rgb_d = 24'hFFFF00;
      end else if (edge_q) begin
        rgb_d = 24'hFFFFFF;
      end else begin
        case (cell_rd)
          2'd0:    rgb_d = 24'h202020;
          2'd1:    rgb_d = 24'hFF0000;
          2'd2:    rgb_d = 24'h0000FF;
          default: rgb_d = 24'h00FF00;
        endcase
      end
    end
  end

  // Stage-2 output register; syncs delayed to stay aligned with RGB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q <= 24'h000000;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Testbench for vga_board_renderer: directed scenarios plus random pixels/writes/cursor moves,
// compared every clock against a board-level model computed from pixel coordinates.
module tb_vga_board_renderer;

  localparam int X0 = 160;
  localparam int Y0 = 80;
  localparam int CL = 6;
  localparam int NC = 3;
  localparam int NR = 3;
  localparam int CS = 1 << CL;
`ifdef CURSOR_BLINK_EN
  localparam int BF = 30;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       vid_on = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_col = '0;
  logic [2:0] wr_row = '0;
  logic [1:0] wr_data = '0;
  logic [2:0] cur_col = '0;
  logic [2:0] cur_row = '0;
  logic       hsync_out, vsync_out;
  logic [7:0] red, green, blue;

  vga_board_renderer #(
    .GRID_X0(X0), .GRID_Y0(Y0), .CELL_LOG2(CL), .COLS(NC), .ROWS(NR)
`ifdef CURSOR_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clock(clock), .reset(reset), .h_count(h_count), .v_count(v_count), .vid_on(vid_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .cur_col(cur_col), .cur_row(cur_row), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .red(red), .green(green), .blue(blue)
  );

  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int h; int v; bit vid; bit hs; bit vs; } pix_t;

  pix_t        pend;            // pixel accepted at the previous edge
  int          mc [NR][NC];     // board contents
  int          frame_ends;
  logic [23:0] exp_rgb;
  logic        exp_hs, exp_vs;

  function automatic logic [23:0] colour(pix_t p);
    int dx, dy, c, r;
    bit e, vis;
    if (!p.vid) return 24'h000000;
    dx = p.h - X0;
    dy = p.v - Y0;
    if (dx < 0 || dy < 0 || dx >= NC * CS || dy >= NR * CS) return 24'h000000;
    c = dx / CS;
    r = dy / CS;
    e = (dx % CS == 0) || (dx % CS == CS - 1) || (dy % CS == 0) || (dy % CS == CS - 1);
    vis = 1'b1;
`ifdef CURSOR_BLINK_EN
    vis = ((frame_ends / BF) % 2) == 0;
`endif
    if (e && int'(cur_col) == c && int'(cur_row) == r && vis) return 24'hFFFF00;
    if (e) return 24'hFFFFFF;
    case (mc[r][c])
      0:       return 24'h202020;
      1:       return 24'hFF0000;
      2:       return 24'h0000FF;
      default: return 24'h00FF00;
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        mc[r][c] = 0;
    pend       = '{0, 0, 1'b0, 1'b1, 1'b1};
    frame_ends = 0;
    exp_rgb    = 24'h000000;
    exp_hs     = 1'b1;
    exp_vs     = 1'b1;
  endtask

  task automatic model_edge();
    exp_rgb = colour(pend);
    exp_hs  = pend.hs;
    exp_vs  = pend.vs;
    if (wr_en && int'(wr_col) < NC && int'(wr_row) < NR) mc[wr_row][wr_col] = int'(wr_data);
`ifdef CURSOR_BLINK_EN
    if (h_count == 10'd799 && v_count == 10'd524) frame_ends++;
`endif
    pend = '{int'(h_count), int'(v_count), vid_on, hsync_in, vsync_in};
  endtask

  // One clock: advance model at the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clock);
    if (reset) model_reset();
    else model_edge();
    #1;
    check("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb});
    check("hsync", {31'h0, hsync_out}, {31'h0, exp_hs});
    check("vsync", {31'h0, vsync_out}, {31'h0, exp_vs});
  endtask

  task automatic set_px(input int h, input int v, input bit vid);
    h_count  = 10'(h);
    v_count  = 10'(v);
    vid_on   = vid;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, {8'h0, red, green, blue}, 32'h0);
    check({tag, "_hs"}, {31'h0, hsync_out}, 32'h1);
    check({tag, "_vs"}, {31'h0, vsync_out}, 32'h1);
  endtask

  int low_cnt, first_low;

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Origin pixel, outside the board.
    set_px(0, 0, 1);
    step(); step();
    check("origin_rgb", {8'h0, red, green, blue}, 32'h0);
    check("origin_hs", {31'h0, hsync_out}, 32'h1);

    // Player A in cell (1,1), centre pixel.
    wr_en = 1'b1; wr_col = 3'd1; wr_row = 3'd1; wr_data = 2'd1;
    step();
    wr_en = 1'b0;
    set_px(X0 + 96, Y0 + 96, 1);
    step(); step();
    check("cell11_red", {8'h0, red, green, blue}, 32'h00FF0000);

    // Cell outline with and without the cursor on that cell.
    set_px(X0 + 64, Y0 + 10, 1);
    cur_col = 3'd0; cur_row = 3'd2;
    step(); step();
    check("edge_white", {8'h0, red, green, blue}, 32'h00FFFFFF);
    cur_col = 3'd1; cur_row = 3'd0;
    step(); step();
    check("edge_cursor", {8'h0, red, green, blue}, 32'h00FFFF00);

    // Out-of-range cursor draws nothing special.
    cur_col = 3'd3; cur_row = 3'd0;
    step(); step();
    check("cursor_oor", {8'h0, red, green, blue}, 32'h00FFFFFF);

    // Out-of-range writes, then a scan of all cells.
    wr_en = 1'b1; wr_col = 3'd3; wr_row = 3'd1; wr_data = 2'd2;
    step();
    wr_col = 3'd1; wr_row = 3'd5; wr_data = 2'd3;
    step();
    wr_en = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        set_px(X0 + c * CS + 32, Y0 + r * CS + 32, 1);
        step();
      end
    step(); step();

    // Same-cycle write and read of cell col 2 row 0.
    set_px(X0 + 2 * CS + 32, Y0 + 32, 1);
    step();
    wr_en = 1'b1; wr_col = 3'd2; wr_row = 3'd0; wr_data = 2'd2;
    step();
    wr_en = 1'b0;
    check("wr_rd_old", {8'h0, red, green, blue}, 32'h00202020);
    step();
    check("wr_rd_new", {8'h0, red, green, blue}, 32'h000000FF);

    // vid_on low inside the board.
    set_px(X0 + 96, Y0 + 96, 0);
    step(); step();
    check("blank_in_grid", {8'h0, red, green, blue}, 32'h0);

    // Horizontal sync pulse during blanking.
    low_cnt = 0; first_low = -1;
    for (int i = 0; i <= 130; i++) begin
      set_px(640 + i, Y0 + 10, 0);
      hsync_in = !((640 + i) >= 655 && (640 + i) <= 750);
      step();
      if (hsync_out == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hsync_low_len", 32'(low_cnt), 32'd96);
    check("hsync_low_start", 32'(first_low), 32'd16);

`ifdef CURSOR_BLINK_EN
    cur_col = 3'd1; cur_row = 3'd0;
    for (int f = 0; f < 2 * BF + 2; f++) begin
      set_px(X0 + 64, Y0 + 10, 1);
      step(); step(); step();
      set_px(799, 524, 0);
      step();
    end
`endif

    // Random pixels, writes and cursor moves, with one mid-frame reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7, 0) == 0) begin
        h_count = 10'($urandom_range(799, 0));
        v_count = 10'($urandom_range(524, 0));
      end else begin
        h_count = 10'($urandom_range(X0 + NC * CS + 20, X0 - 20));
        v_count = 10'($urandom_range(Y0 + NR * CS + 20, Y0 - 20));
      end
      if ($urandom_range(199, 0) == 0) begin
        h_count = 10'd799;
        v_count = 10'd524;
      end
      vid_on   = ($urandom_range(7, 0) != 0);
      hsync_in = ($urandom_range(5, 0) != 0);
      vsync_in = ($urandom_range(5, 0) != 0);
      wr_en    = ($urandom_range(3, 0) == 0);
      wr_col   = 3'($urandom_range(4, 0));
      wr_row   = 3'($urandom_range(4, 0));
      wr_data  = 2'($urandom_range(3, 0));
      if ($urandom_range(15, 0) == 0) begin
        cur_col = 3'($urandom_range(3, 0));
        cur_row = 3'($urandom_range(3, 0));
      end
      step();
      if (n == 1500) begin
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        step();
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
